axis_pkt_buf_reader: RTL and testbench
======================================

Name: axis_pkt_buf_reader

Overview:
- Read-side engine for the dual-port packet buffer RAM.
- Takes a packet descriptor (start address, byte length), issues reads on the RAM's registered read port (enb/addrb/db_o), and emits the packet as a 32-bit AXI-Stream master with tkeep/tlast.
- Sits between the buffer RAM read port and the TX datapath; full throughput under tready=1, lossless under backpressure.

Parameters:
- DEPTH, 512, RAM words; addresses wrap modulo DEPTH.
- ADDR_W, 9, RAM address width (= $clog2(DEPTH)).
- DATA_W, 32, word width; tkeep width = DATA_W/8.
- LEN_W, 11, byte-length width (max 2047 bytes).

Ports:
- clk_i  in  1  block clock; RAM read port is clocked by the same clock.
- rst_i  in  1  synchronous, active-high reset.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor accept; high only in IDLE.
- desc_addr_i  in  ADDR_W  first word address.
- desc_len_i  in  LEN_W  packet length in bytes.
- rd_en_o  out  1  RAM read enable (to enb).
- rd_addr_o  out  ADDR_W  RAM read address (to addrb).
- rd_data_i  in  DATA_W  RAM read data (db_o); valid 1 cycle after rd_en_o.
- m_axis_tdata_o  out  DATA_W  stream data.
- m_axis_tkeep_o  out  DATA_W/8  byte enables.
- m_axis_tlast_o  out  1  last beat of packet.
- m_axis_tvalid_o  out  1  beat valid.
- m_axis_tready_i  in  1  downstream ready.
- busy_o  out  1  high from descriptor accept through final handshake.
- done_o  out  1  one-cycle pulse after tlast handshake.

Behaviour:
- Reset (sync, any state): state=IDLE, FIFO flushed, outstanding read dropped. Outputs: desc_ready_o=1, rd_en_o=0, rd_addr_o=0, tvalid=0, tlast=0, tdata=0, tkeep=0, busy_o=0, done_o=0. A packet in flight is abandoned with no done_o.
- Descriptor handshake: desc_valid_i & desc_ready_o. Latch addr, words=ceil(len/4), rem=len[1:0].
- desc_len_i==0: handshake completes, no reads, no beats, done_o pulses the next cycle.
- State machine:
  - IDLE -> READ on a handshake with len>0.
  - READ: issue one read per cycle while credit allows; rd_addr increments, wrapping DEPTH-1 -> 0. Go to DRAIN after the last read is issued.
  - DRAIN: go to IDLE on the tlast handshake.
- Credit rule: rd_en_o=1 only if (FIFO occupancy + reads in flight) < 2. This guarantees no overflow at 1-cycle RAM latency.
- Buffering: 2-entry FIFO captures rd_data_i the cycle after rd_en_o. The stream is driven from the FIFO head.
- Latency: handshake at edge T -> first rd_en_o cycle T+1 -> first tvalid cycle T+2.
- Throughput: with tready held high, 1 beat per cycle and no bubbles.
- AXI-Stream rules:
  - Once tvalid=1, tdata/tkeep/tlast hold until tready=1.
  - tvalid never depends combinationally on tready.
- tkeep: 4'hF on all non-last beats. Last beat by rem: 0 -> 4'hF, 1 -> 4'h1, 2 -> 4'h3, 3 -> 4'h7.
- tlast: high only on beat number `words`.
- Single-word packet: READ -> DRAIN after one read; tlast on the first beat.
- Completion: done_o=1 and busy_o=0 the cycle after the tlast handshake; desc_ready_o=1 in that same cycle. A back-to-back descriptor may be accepted then.
- tready deasserted mid-packet: reads stop at the credit limit, the FIFO holds 2 words, and no data is lost or reordered.

Decomposition:
- Package eth_axis_pkg holds:
  - DATA_W/KEEP_W constants;
  - state enum {IDLE, READ, DRAIN};
  - function rem2keep(logic [1:0]) returning tkeep.
- Sub-module axis_fifo2 (2-entry synchronous FIFO with push/pop/occupancy) holds the FIFO; the FSM, counters and credit logic live at top level.

Test Plan:
- Descriptor addr=0x010, len=64, tready=1 -> 16 beats on consecutive cycles T+2..T+17, tkeep=F throughout, tlast on beat 16, done_o at T+18.
- addr=0x1FE, len=13 -> reads at 0x1FE, 0x1FF, 0x000, 0x001; 4 beats; last tkeep=4'h1.
- len=64 with tready toggled 1/0 every cycle, then held 0 for 10 cycles -> no more than 2 reads outstanding+buffered; data sequence identical to RAM contents; tvalid/tdata stable while stalled.
- len=3 (single word) -> one beat, tkeep=4'h7, tlast=1. Then len=0 -> no beats, done_o pulses once.
- Back-to-back descriptors (len=8, then len=6 offered on the done cycle) -> second accepted immediately; beats 2+2 with last tkeep 4'h3; no gap beyond the 2-cycle latency.
- rst_i asserted mid-packet after beat 5 of 16 -> next cycle tvalid=0, busy_o=0, desc_ready_o=1, no done_o; a fresh descriptor then streams correctly.

Source files
------------

// File: rtl/eth_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_axis_pkg
//  Purpose  : Shared stream widths, reader state encoding and keep decoding.
//  Revision : 1.0
// ============================================================================
package eth_axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Byte enables for the final beat, indexed by the byte length modulo 4.
  function automatic logic [AXIS_KEEP_W-1:0] rem2keep(input logic [1:0] rem);
    logic [AXIS_KEEP_W-1:0] keep;
    case (rem)
      2'd1:    keep = 4'h1;
      2'd2:    keep = 4'h3;
      2'd3:    keep = 4'h7;
      default: keep = 4'hF;
    endcase
    return keep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fifo2
//  Purpose  : 2-entry synchronous FIFO with fall-through of the incoming word.
//  Revision : 1.0
// ============================================================================
module axis_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;

  logic w_empty;
  logic w_pop;
  logic w_store;
  logic w_drop;

  // An empty FIFO presents the word arriving this cycle, so a read lands on
  // the stream the same cycle the RAM returns it; only unconsumed words are stored.
  assign w_empty = (r_occ == 2'd0);
  assign o_valid = !w_empty || i_push;
  assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  assign w_pop   = i_pop && o_valid;
  assign w_store = i_push && !(w_empty && w_pop);
  assign w_drop  = w_pop && !w_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_drop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_store, w_drop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_buf_reader.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkt_buf_reader
//  Purpose  : Reads a packet from the buffer RAM and emits it as AXI-Stream.
//  Revision : 1.0
// ============================================================================
module axis_pkt_buf_reader
  import eth_axis_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = AXIS_DATA_W,
  parameter int LEN_W  = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                desc_valid_i,
  output logic                desc_ready_o,
  input  logic [ADDR_W-1:0]   desc_addr_i,
  input  logic [LEN_W-1:0]    desc_len_i,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  output logic [DATA_W-1:0]   m_axis_tdata_o,
  output logic [DATA_W/8-1:0] m_axis_tkeep_o,
  output logic                m_axis_tlast_o,
  output logic                m_axis_tvalid_o,
  input  logic                m_axis_tready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int                c_CNT_W     = LEN_W - 1;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  rd_state_t            r_state;
  rd_state_t            w_state_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [c_CNT_W-1:0]   r_rd_left;
  logic [c_CNT_W-1:0]   r_beats_left;
  logic [1:0]           r_rem;
  logic                 r_inflight;
  logic                 r_done;

  logic                 w_desc_hs;
  logic                 w_len_zero;
  logic [LEN_W:0]       w_len_p3;
  logic [c_CNT_W-1:0]   w_words;
  logic [2:0]           w_pending;
  logic                 w_credit_ok;
  logic                 w_rd_en;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_fifo_valid;
  logic [DATA_W-1:0]    w_fifo_data;
  logic [1:0]           w_fifo_occ;

  assign w_desc_hs  = desc_valid_i && (r_state == IDLE);
  assign w_len_zero = (desc_len_i == '0);
  assign w_len_p3   = {1'b0, desc_len_i} + (LEN_W+1)'(3);
  assign w_words    = w_len_p3[LEN_W:2];

  // Words buffered plus the read still in the RAM pipeline must stay below
  // the FIFO depth, so a stalled stream can never overflow the FIFO.
  assign w_pending   = {1'b0, w_fifo_occ} + {2'b00, r_inflight};
  assign w_credit_ok = (w_pending < 3'd2);

  assign w_beat      = w_fifo_valid && m_axis_tready_i;
  assign w_last_beat = (r_beats_left == c_ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_desc_hs && !w_len_zero) begin
          w_state_next = READ;
        end
      end
      READ: begin
        w_rd_en = w_credit_ok;
        if (w_credit_ok && (r_rd_left == c_ONE)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_beat && w_last_beat) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_rd_left    <= '0;
      r_beats_left <= '0;
      r_rem        <= 2'd0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= (w_desc_hs && w_len_zero) || (w_beat && w_last_beat);
      if (w_desc_hs) begin
        r_addr       <= desc_addr_i;
        r_rd_left    <= w_words;
        r_beats_left <= w_words;
        r_rem        <= desc_len_i[1:0];
      end else begin
        if (w_rd_en) begin
          r_addr    <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
          r_rd_left <= r_rd_left - c_ONE;
        end
        if (w_beat) begin
          r_beats_left <= r_beats_left - c_ONE;
        end
      end
    end
  end

  axis_fifo2 #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (r_inflight),
    .i_data  (rd_data_i),
    .i_pop   (m_axis_tready_i),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_occ   (w_fifo_occ)
  );

  assign desc_ready_o    = (r_state == IDLE);
  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
  assign rd_en_o         = w_rd_en;
  assign rd_addr_o       = r_addr;

  // Stream sideband is forced to zero whenever no beat is presented.
  assign m_axis_tvalid_o = w_fifo_valid;
  assign m_axis_tdata_o  = w_fifo_valid ? w_fifo_data : '0;
  assign m_axis_tlast_o  = w_fifo_valid && w_last_beat;
  assign m_axis_tkeep_o  = !w_fifo_valid ? '0 :
                           (w_last_beat ? rem2keep(r_rem) : '1);

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_buf_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pkt_buf_reader
//  Purpose  : Randomised and directed bench with a queue-based packet model.
//  Revision : 1.0
// ============================================================================
module tb_axis_pkt_buf_reader;

  logic        clk;
  logic        rst_i;
  logic        desc_valid;
  logic        desc_ready;
  logic [8:0]  desc_addr;
  logic [10:0] desc_len;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        done;

  axis_pkt_buf_reader dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .desc_valid_i    (desc_valid),
    .desc_ready_o    (desc_ready),
    .desc_addr_i     (desc_addr),
    .desc_len_i      (desc_len),
    .rd_en_o         (rd_en),
    .rd_addr_o       (rd_addr),
    .rd_data_i       (rd_data),
    .m_axis_tdata_o  (tdata),
    .m_axis_tkeep_o  (tkeep),
    .m_axis_tlast_o  (tlast),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer RAM with a registered read port.
  logic [31:0] mem [512];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          t;
  } beat_t;

  beat_t      q[$];
  logic [8:0] aq[$];
  logic [8:0] rd_log[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_beat = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit strict = 0;
  int mode = 0;
  bit hold_v = 0;
  logic [36:0] hold_w;
  int pkt_beats, done_cnt, first_beat_cyc, first_done_cyc, last_done_cyc, last_hs_cyc;
  logic [3:0] last_keep;
  logic       last_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] keep_for(input int r);
    case (r)
      1:       return 4'h1;
      2:       return 4'h3;
      3:       return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  // A packet of len bytes is ceil(len/4) consecutive RAM words, wrapping at 512.
  task automatic push_pkt(input int a0, input int len, input int t0);
    int w;
    beat_t b;
    w = (len + 3) / 4;
    for (int i = 0; i < w; i++) begin
      b.d = mem[(a0 + i) % 512];
      b.l = (i == w - 1);
      b.k = b.l ? keep_for(len % 4) : 4'hF;
      b.t = t0 + 2 + i;
      q.push_back(b);
      aq.push_back(9'((a0 + i) % 512));
    end
  endtask

  task automatic clear_logs();
    pkt_beats = 0; done_cnt = 0; first_beat_cyc = -1; first_done_cyc = -1;
    last_done_cyc = -1; last_hs_cyc = -1; last_keep = 4'h0; last_last = 1'b0;
    rd_log.delete();
  endtask

  always @(negedge clk) begin
    bit nb, nd;
    if (rst_i) begin
      q.delete(); aq.delete();
      m_busy = 0; m_done = 0; n_rd = 0; n_beat = 0; hold_v = 0;
    end else begin
      chk("desc_ready", desc_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) begin
        done_cnt++;
        if (first_done_cyc < 0) first_done_cyc = cyc;
        last_done_cyc = cyc;
      end
      if (strict) begin
        if (q.size() > 0) chk("tvalid_timing", tvalid, cyc >= q[0].t);
        else              chk("tvalid_timing", tvalid, 0);
      end else if (q.size() == 0) begin
        chk("tvalid_idle", tvalid, 0);
      end
      if (hold_v) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_beat", {tdata, tkeep, tlast}, hold_w);
      end
      if (tvalid && q.size() > 0) begin
        chk("tdata", tdata, q[0].d);
        chk("tkeep", tkeep, q[0].k);
        chk("tlast", tlast, q[0].l);
      end
      if (rd_en) begin
        chk("credit", (n_rd - n_beat) < 2, 1);
        chk("read_expected", aq.size() > 0, 1);
        if (aq.size() > 0) begin
          chk("rd_addr", rd_addr, aq[0]);
          void'(aq.pop_front());
        end
        rd_log.push_back(rd_addr);
        n_rd++;
      end
      nb = m_busy;
      nd = 0;
      if (tvalid && tready && q.size() > 0) begin
        n_beat++;
        pkt_beats++;
        last_keep = tkeep;
        last_last = tlast;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (q[0].l) begin nb = 0; nd = 1; end
        void'(q.pop_front());
      end
      hold_v = tvalid && !tready;
      hold_w = {tdata, tkeep, tlast};
      if (desc_valid && desc_ready) begin
        last_hs_cyc = cyc;
        if (desc_len == 0) nd = 1;
        else begin
          nb = 1;
          push_pkt(int'(desc_addr), int'(desc_len), cyc);
        end
      end
      m_busy = nb;
      m_done = nd;
    end
    cyc++;
  end

  // Downstream ready: 0 full rate, 1 toggle, 2 random, 3 stalled.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       tready = ~tready;
        2:       tready = 1'($urandom_range(0, 1));
        3:       tready = 1'b0;
        default: tready = 1'b1;
      endcase
    end
  end

  task automatic send_desc(input logic [8:0] a, input logic [10:0] l);
    int n;
    @(posedge clk); #1;
    desc_valid = 1'b1; desc_addr = a; desc_len = l;
    n = 0;
    @(negedge clk);
    while (!desc_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("desc_timeout", n < 5000, 1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", n < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    rst_i = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Full-rate 64-byte packet.
    clear_logs(); strict = 1; mode = 0;
    send_desc(9'h010, 11'd64);
    wait_idle();
    chk("t1_beats", pkt_beats, 16);
    chk("t1_first_lat", first_beat_cyc - last_hs_cyc, 2);
    chk("t1_done_lat", last_done_cyc - last_hs_cyc, 18);
    chk("t1_last_keep", last_keep, 4'hF);

    // Address wrap.
    clear_logs();
    send_desc(9'h1FE, 11'd13);
    wait_idle();
    chk("t2_nreads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("t2_rd0", rd_log[0], 9'h1FE);
      chk("t2_rd1", rd_log[1], 9'h1FF);
      chk("t2_rd2", rd_log[2], 9'h000);
      chk("t2_rd3", rd_log[3], 9'h001);
    end
    chk("t2_beats", pkt_beats, 4);
    chk("t2_last_keep", last_keep, 4'h1);

    // Backpressure: toggle, then a long stall.
    clear_logs(); strict = 0;
    send_desc(9'h100, 11'd64);
    mode = 1;
    repeat (20) @(posedge clk);
    mode = 3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_fifo_full", n_rd - n_beat, 2);
    chk("t3_tvalid_held", tvalid, 1);
    mode = 0;
    wait_idle();
    chk("t3_beats", pkt_beats, 16);

    // Single-word packet, then zero length.
    clear_logs(); strict = 1;
    send_desc(9'h050, 11'd3);
    wait_idle();
    chk("t4_beats", pkt_beats, 1);
    chk("t4_keep", last_keep, 4'h7);
    chk("t4_last", last_last, 1);
    clear_logs();
    send_desc(9'h060, 11'd0);
    wait_idle();
    chk("t4_zero_beats", pkt_beats, 0);
    chk("t4_zero_done", done_cnt, 1);

    // Back-to-back descriptors.
    clear_logs();
    send_desc(9'h080, 11'd8);
    send_desc(9'h0A0, 11'd6);
    wait_idle();
    chk("t5_accept_on_done", last_hs_cyc, first_done_cyc);
    chk("t5_beats", pkt_beats, 4);
    chk("t5_last_keep", last_keep, 4'h3);
    chk("t5_done_cnt", done_cnt, 2);

    // Reset mid-packet after beat 5, then a fresh packet.
    clear_logs();
    send_desc(9'h0C0, 11'd64);
    n = 0;
    @(posedge clk);
    while (pkt_beats < 5 && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk("t6_wait_beats", n < 200, 1);
    mode = 3;
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", desc_ready, 1);
    chk("t6_done", done, 0);
    chk("t6_beats_before", pkt_beats, 5);
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    mode = 0;
    clear_logs();
    send_desc(9'h1F0, 11'd37);
    wait_idle();
    chk("t6_fresh_beats", pkt_beats, 10);
    chk("t6_fresh_keep", last_keep, 4'h1);

    // Randomised descriptors under random backpressure.
    strict = 0; mode = 2;
    for (int p = 0; p < 12; p++) begin
      send_desc(9'($urandom_range(0, 511)), 11'($urandom_range(0, 100)));
    end
    mode = 0;
    wait_idle();
    chk("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
